// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   state_e   : control FSM states (IDLE / RUN / DONE)
//   op_e      : captured operation (MULT / DIV)
//   cnt_width : width of the iteration counter for a given operand width
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_iter_datapath.sv
// Accumulator / shift datapath shared by multiply and divide.
// Works on unsigned operand magnitudes; sign handling lives in the top level.
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : initialise registers from load_d / load_q
//   step           : perform one iteration
//   op             : operation of the running job
//   load_d         : multiplicand (MULT) or divisor (DIV) magnitude
//   load_q         : multiplier (MULT) or dividend (DIV) magnitude
//   step_hi        : product high half after the current iteration
//   step_lo        : product low half / quotient after the current iteration
// The step_* outputs show the value the registers take at the next step, so
// the top level can fix up and register the result on the final iteration edge.
module multdiv_iter_datapath
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  op_e              op,
  input  logic [WIDTH-1:0] load_d,
  input  logic [WIDTH-1:0] load_q,
  output logic [WIDTH-1:0] step_hi,
  output logic [WIDTH-1:0] step_lo
);

  // acc is signed W+2 bits: the non-restoring remainder needs one extra
  // magnitude bit plus a sign; the multiply only uses the low W+1 bits.
  logic [WIDTH+1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH+1:0] shifted, sum;
  logic             unused_acc_top;

  always_comb begin
    acc_next = acc_reg;
    q_next   = q_reg;
    shifted  = '0;
    sum      = '0;
    if (op == OP_MULT) begin
      // Shift-add: conditionally add multiplicand, then shift {acc,q} right.
      sum      = {1'b0, acc_reg[WIDTH:0]} + {2'b00, (q_reg[0] ? d_reg : {WIDTH{1'b0}})};
      acc_next = {1'b0, sum[WIDTH+1:1]};
      q_next   = {sum[0], q_reg[WIDTH-1:1]};
    end else begin
      // Non-restoring: shift {r,q} left, subtract if r was non-negative,
      // add otherwise; the new quotient bit is the inverted remainder sign.
      shifted  = {acc_reg[WIDTH:0], q_reg[WIDTH-1]};
      if (acc_reg[WIDTH+1])
        sum = shifted + {2'b00, d_reg};
      else
        sum = shifted - {2'b00, d_reg};
      acc_next = sum;
      q_next   = {q_reg[WIDTH-2:0], ~sum[WIDTH+1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg <= '0;
      q_reg   <= '0;
      d_reg   <= '0;
    end else if (load) begin
      acc_reg <= '0;
      q_reg   <= load_q;
      d_reg   <= load_d;
    end else if (step) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
    end
  end

  assign step_hi        = acc_next[WIDTH-1:0];
  assign step_lo        = q_next;
  assign unused_acc_top = ^acc_next[WIDTH+1:WIDTH];

endmodule

// File: rtl/multdiv_iter_unit.sv
// Multi-cycle signed multiply / divide unit (one operation at a time).
//   clock, reset_n      : clock and asynchronous active-low reset
//   ctrl_mult, ctrl_div : start pulses (multiply wins if both are high)
//   flush               : abort an in-flight operation, blocks accept in IDLE
//   op_a, op_b          : multiplicand/dividend, multiplier/divisor
//   ir_in               : instruction word captured at accept
//   busy, ready         : state != IDLE, one-cycle completion pulse
//   result, exception   : product low half or quotient, overflow / div-by-zero
//   ir_out              : instruction word of the completed operation
// Optional build macro MULTDIV_EARLY_OUT_EN: a zero divisor, or a zero
// multiply operand, completes straight from IDLE into DONE.
module multdiv_iter_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IR_W  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [IR_W-1:0]  ir_in,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [IR_W-1:0]  ir_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  op_e               op_reg;
  logic              neg_reg, b_zero_reg;
  logic [IR_W-1:0]   ir_reg, ir_out_reg;
  logic [WIDTH-1:0]  result_reg;
  logic              exception_reg;

  logic              accept, early, last_step;
  logic [WIDTH-1:0]  mag_a, mag_b, dp_hi, dp_lo;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]    prod_upper;
  logic [WIDTH-1:0]  quo_signed, fix_result;
  logic              fix_exception;

  assign accept    = (state_reg == ST_IDLE) && !flush && (ctrl_mult || ctrl_div);
  assign last_step = (state_reg == ST_RUN) && !flush && (cnt_reg == LAST_CNT);
  assign mag_a     = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b     = op_b[WIDTH-1] ? -op_b : op_b;

`ifdef MULTDIV_EARLY_OUT_EN
  assign early = ctrl_mult ? ((op_a == '0) || (op_b == '0)) : (op_b == '0);
`else
  assign early = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = early ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (flush)                     state_next = ST_IDLE;
        else if (cnt_reg == LAST_CNT)  state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode (from registered state only)
  always_comb begin
    busy  = (state_reg != ST_IDLE);
    ready = (state_reg == ST_DONE);
  end

  multdiv_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .step    (state_reg == ST_RUN),
    .op      (op_reg),
    .load_d  (ctrl_mult ? mag_a : mag_b),
    .load_q  (ctrl_mult ? mag_b : mag_a),
    .step_hi (dp_hi),
    .step_lo (dp_lo)
  );

  // Sign fix-up on the magnitude result of the final iteration.
  always_comb begin
    prod_signed   = neg_reg ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
    prod_upper    = prod_signed[2*WIDTH-1:WIDTH-1];
    quo_signed    = neg_reg ? -dp_lo : dp_lo;
    fix_result    = '0;
    fix_exception = 1'b0;
    if (op_reg == OP_MULT) begin
      fix_result    = prod_signed[WIDTH-1:0];
      // Fits in signed WIDTH only if the top WIDTH+1 bits are a sign extension.
      fix_exception = !((&prod_upper) || (~|prod_upper));
    end else if (b_zero_reg) begin
      fix_result    = '0;
      fix_exception = 1'b1;
    end else begin
      fix_result    = quo_signed;
      // A positive quotient with the top bit set can only be MIN / -1.
      fix_exception = !neg_reg && dp_lo[WIDTH-1];
    end
  end

  // Counter, capture and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      op_reg        <= OP_MULT;
      neg_reg       <= 1'b0;
      b_zero_reg    <= 1'b0;
      ir_reg        <= '0;
      ir_out_reg    <= '0;
      result_reg    <= '0;
      exception_reg <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg    <= '0;
        op_reg     <= ctrl_mult ? OP_MULT : OP_DIV;
        neg_reg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        b_zero_reg <= (op_b == '0);
        ir_reg     <= ir_in;
        if (early) begin
          result_reg    <= '0;
          exception_reg <= !ctrl_mult;
          ir_out_reg    <= ir_in;
        end
      end else if (state_reg == ST_RUN) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (last_step) begin
        result_reg    <= fix_result;
        exception_reg <= fix_exception;
        ir_out_reg    <= ir_reg;
      end
    end
  end

  assign result    = result_reg;
  assign exception = exception_reg;
  assign ir_out    = ir_out_reg;

endmodule

// File: tb/tb_multdiv_iter_unit.sv
module tb_multdiv_iter_unit;

  localparam int W = 32;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam int ZERO_EDGES = 0;
`else
  localparam int ZERO_EDGES = W;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          ctrl_mult, ctrl_div, flush;
  logic [W-1:0]  op_a, op_b;
  logic [31:0]   ir_in;
  logic          busy, ready, exception;
  logic [W-1:0]  result;
  logic [31:0]   ir_out;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;

  multdiv_iter_unit #(.WIDTH(W), .IR_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ctrl_mult (ctrl_mult),
    .ctrl_div  (ctrl_div),
    .flush     (flush),
    .op_a      (op_a),
    .op_b      (op_b),
    .ir_in     (ir_in),
    .busy      (busy),
    .ready     (ready),
    .result    (result),
    .exception (exception),
    .ir_out    (ir_out)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (ready) ready_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait for ready. edges counts clock edges after
  // the accept edge E0 at which ready is first seen high.
  task automatic run_op(input string tag, input bit is_mult,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] ir,
                        input logic [31:0] exp_res, input bit exp_exc, input int exp_edges);
    int edges;
    @(negedge clock);
    ctrl_mult = is_mult;
    ctrl_div  = !is_mult;
    op_a = a; op_b = b; ir_in = ir;
    @(negedge clock);
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    op_a = $urandom; op_b = $urandom; ir_in = $urandom;
    check({tag, "_busy"}, busy, 1);
    edges = 0;
    while (!ready && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_exc"}, exception, exp_exc);
    check({tag, "_ir"}, ir_out, ir);
    @(negedge clock);
    check({tag, "_ready_off"}, ready, 0);
    check({tag, "_idle"}, busy, 0);
    $display("op %s a=%08h b=%08h -> result=%08h exc=%0d ir=%08h edges=%0d",
             tag, a, b, result, exception, ir_out, edges);
  endtask

  initial begin
    int rc;
    reset_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; ir_in = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_result", result, 0);
    check("rst_exc", exception, 0);
    check("rst_ir", ir_out, 0);
    $display("reset busy=%0d ready=%0d result=%08h", busy, ready, result);
    reset_n = 1'b1;

    run_op("mul_7x-6",   1'b1, 32'd7,          32'hFFFF_FFFA, 32'hA000_0001, 32'hFFFF_FFD6, 1'b0, W);
    run_op("mul_ovf",    1'b1, 32'h0001_0000,  32'h0001_0000, 32'hA000_0002, 32'h0000_0000, 1'b1, W);
    run_op("div_-7/2",   1'b0, 32'hFFFF_FFF9,  32'd2,         32'hA000_0003, 32'hFFFF_FFFD, 1'b0, W);
    run_op("div_5/0",    1'b0, 32'd5,          32'd0,         32'hA000_0004, 32'h0000_0000, 1'b1, ZERO_EDGES);
    run_op("mul_0x9",    1'b1, 32'd0,          32'd9,         32'hA000_0005, 32'h0000_0000, 1'b0, ZERO_EDGES);
    run_op("div_min/-1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'hA000_0006, 32'h8000_0000, 1'b1, W);

    // Flush test: multiply in flight, ignored divide pulse, then flush.
    @(negedge clock);
    ctrl_mult = 1'b1; op_a = 32'd9; op_b = 32'd9; ir_in = 32'hB000_0001;
    @(negedge clock);
    ctrl_mult = 1'b0;
    rc = ready_cnt;
    repeat (4) @(negedge clock);
    ctrl_div = 1'b1; op_a = 32'd100; op_b = 32'd7; ir_in = 32'hB000_0002;
    @(negedge clock);
    ctrl_div = 1'b0;
    repeat (4) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    repeat (40) @(negedge clock);
    check("flush_no_ready", ready_cnt - rc, 0);
    check("flush_still_idle", busy, 0);
    check("flush_result_kept", result, 32'h8000_0000);
    check("flush_exc_kept", exception, 1);
    check("flush_ir_kept", ir_out, 32'hA000_0006);
    $display("flush busy=%0d result=%08h ready_pulses=%0d", busy, result, ready_cnt - rc);

    run_op("mul_3x4",    1'b1, 32'd3,          32'd4,         32'hA000_0007, 32'h0000_000C, 1'b0, W);

    // Asynchronous reset in the middle of an operation.
    @(negedge clock);
    ctrl_mult = 1'b1; op_a = 32'd5; op_b = 32'd5; ir_in = 32'hC000_0001;
    @(negedge clock);
    ctrl_mult = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_ir", ir_out, 0);
    $display("async reset busy=%0d result=%08h ir=%08h", busy, result, ir_out);
    @(negedge clock);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
